io_bus_reg_slave: RTL and testbench

- Slave-side endpoint for the 32-bit IO_bus. Sits directly downstream of the bus master, with one instance per I/O subsystem.
- Decodes a contiguous register window and completes a 4-phase handshake_1/handshake_2 transfer.
- Presents read/write config registers to the subsystem and returns read-only status words to the master.
- Outputs are flat; the top level muxes data_in/handshake_2 from all slaves onto the interface using `selected`.

---
 rtl/io_bus_pkg.sv | 22 ++
 rtl/io_addr_decode.sv | 34 +++
 rtl/io_bus_reg_slave.sv | 225 ++++++++++++++++++++++
 tb/tb_io_bus_reg_slave.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_bus_pkg.sv
// Shared definitions for the IO_bus slave endpoint: data width, RW encoding,
// slave FSM state type and an index-width helper.
package io_bus_pkg;

    localparam int REG_WIDTH = 32;

    localparam logic BUS_READ  = 1'b1;
    localparam logic BUS_WRITE = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ACCESS   = 2'd1,
        S_ACK      = 2'd2,
        S_WAIT_LOW = 2'd3
    } slave_state_t;

    // Width of a register index for a window of n registers (at least 1 bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/io_addr_decode.sv
// Register-window decoder for the IO_bus slave. Purely combinational: tells
// whether an address falls inside the window, whether it hits the RW block,
// and which register (counted from BASE_ADDR) it selects.
module io_addr_decode
    import io_bus_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR   = 8'h00,
    parameter int         NUM_RW_REGS = 4,
    parameter int         NUM_RO_REGS = 2,
    localparam int        IDX_W       = idx_width(NUM_RW_REGS + NUM_RO_REGS)
) (
    input  logic [7:0]       reg_address,
    output logic             in_window,
    output logic             is_rw,
    output logic [IDX_W-1:0] reg_idx
);

    // 9-bit bounds so a window ending at 8'hFF cannot wrap back to 8'h00.
    localparam logic [8:0] BASE9 = {1'b0, BASE_ADDR};
    localparam logic [8:0] END9  = BASE9 + 9'(NUM_RW_REGS + NUM_RO_REGS);

    logic [8:0] addr9;
    logic [8:0] offset9;

    // Window compare and offset-to-index conversion.
    always_comb begin
        addr9     = {1'b0, reg_address};
        offset9   = addr9 - BASE9;
        in_window = (addr9 >= BASE9) && (addr9 < END9);
        is_rw     = (offset9 < 9'(NUM_RW_REGS));
        reg_idx   = offset9[IDX_W-1:0];
    end

endmodule

// File: rtl/io_bus_reg_slave.sv
// IO_bus register slave: decodes a contiguous register window, runs the
// 4-phase handshake_1/handshake_2 transfer, holds the RW config registers
// and returns RO status words. Optional handshake timeout is enabled by
// defining IO_BUS_SLAVE_TIMEOUT_EN; without it S_ACK waits indefinitely.
module io_bus_reg_slave
    import io_bus_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR      = 8'h00,
    parameter int         NUM_RW_REGS    = 4,
    parameter int         NUM_RO_REGS    = 2,
    parameter int         TIMEOUT_CYCLES = 255
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [7:0]                       reg_address,
    input  logic                             RW,
    input  logic                             handshake_1,
    input  logic [REG_WIDTH-1:0]             data_out,
    output logic [REG_WIDTH-1:0]             data_in,
    output logic                             handshake_2,
    output logic                             selected,
    output logic [NUM_RW_REGS*REG_WIDTH-1:0] rw_regs,
    output logic [NUM_RW_REGS-1:0]           wr_strobe,
    input  logic [NUM_RO_REGS*REG_WIDTH-1:0] ro_regs,
    output logic                             timeout_err
);

    localparam int IDX_W = idx_width(NUM_RW_REGS + NUM_RO_REGS);

    slave_state_t         state_q, state_d;
    logic                 h1_prev_q;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 is_rw_q, is_rw_d;
    logic                 rnw_q, rnw_d;
    logic [REG_WIDTH-1:0] wdata_q, wdata_d;
    logic [REG_WIDTH-1:0] data_in_q, data_in_d;
    logic [REG_WIDTH-1:0] rw_regs_q [NUM_RW_REGS];
    logic [REG_WIDTH-1:0] rd_data;

    logic                 dec_in_window;
    logic                 dec_is_rw;
    logic [IDX_W-1:0]     dec_idx;
    logic                 start;
    logic                 tmo_expired;

    io_addr_decode #(
        .BASE_ADDR   (BASE_ADDR),
        .NUM_RW_REGS (NUM_RW_REGS),
        .NUM_RO_REGS (NUM_RO_REGS)
    ) u_decode (
        .reg_address (reg_address),
        .in_window   (dec_in_window),
        .is_rw       (dec_is_rw),
        .reg_idx     (dec_idx)
    );

    // Only a rising request starts a transfer; h1_prev_q resets high so a
    // request held across reset is ignored until it drops.
    assign start = handshake_1 && !h1_prev_q;

    assign selected    = (state_q == S_ACCESS) || (state_q == S_ACK);
    assign handshake_2 = (state_q == S_ACK);
    assign data_in     = data_in_q;

`ifdef IO_BUS_SLAVE_TIMEOUT_EN
    localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timeout_err_q, timeout_err_d;

    // Count S_ACK cycles with the request still high; flag is sticky.
    always_comb begin
        tmo_expired   = (state_q == S_ACK) && handshake_1 &&
                        (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
        tmo_cnt_d     = '0;
        if ((state_q == S_ACK) && handshake_1 && !tmo_expired) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
        timeout_err_d = timeout_err_q | tmo_expired;
    end

    // Timeout counter and sticky error register.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    // The timeout limit only matters when the feature is built in.
    logic [31:0] unused_timeout_cfg;
    assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
    assign tmo_expired        = 1'b0;
    assign timeout_err        = 1'b0;
`endif

    // Read mux over the latched register index: RW bank or live status words.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_RW_REGS; i++) begin
            if (is_rw_q && (idx_q == IDX_W'(i))) begin
                rd_data = rw_regs_q[i];
            end
        end
        for (int j = 0; j < NUM_RO_REGS; j++) begin
            if (!is_rw_q && (idx_q == IDX_W'(NUM_RW_REGS + j))) begin
                rd_data = ro_regs[j*REG_WIDTH +: REG_WIDTH];
            end
        end
    end

    // One-cycle write strobe during S_ACCESS for a write that hits the RW bank.
    always_comb begin
        wr_strobe = '0;
        if ((state_q == S_ACCESS) && (rnw_q == BUS_WRITE) && is_rw_q) begin
            for (int i = 0; i < NUM_RW_REGS; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    wr_strobe[i] = 1'b1;
                end
            end
        end
    end

    // Next-state logic for the handshake FSM and the transfer latches.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        idx_d     = idx_q;
        is_rw_d   = is_rw_q;
        rnw_d     = rnw_q;
        wdata_d   = wdata_q;
        data_in_d = data_in_q;
        case (state_q)
            S_IDLE: begin
                if (start && dec_in_window) begin
                    state_d = S_ACCESS;
                    idx_d   = dec_idx;
                    is_rw_d = dec_is_rw;
                    rnw_d   = RW;
                    wdata_d = data_out;
                end
            end
            S_ACCESS: begin
                state_d = S_ACK;
                if (rnw_q == BUS_READ) begin
                    data_in_d = rd_data;
                end
            end
            S_ACK: begin
                if (!handshake_1) begin
                    state_d   = S_IDLE;
                    data_in_d = '0;
                end else if (tmo_expired) begin
                    state_d   = S_WAIT_LOW;
                    data_in_d = '0;
                end
            end
`ifdef IO_BUS_SLAVE_TIMEOUT_EN
            S_WAIT_LOW: begin
                if (!handshake_1) begin
                    state_d = S_IDLE;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state, request edge history and transfer latches.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q   <= S_IDLE;
            h1_prev_q <= 1'b1;
            idx_q     <= '0;
            is_rw_q   <= 1'b0;
            rnw_q     <= 1'b0;
            wdata_q   <= '0;
            data_in_q <= '0;
        end else begin
            state_q   <= state_d;
            h1_prev_q <= handshake_1;
            idx_q     <= idx_d;
            is_rw_q   <= is_rw_d;
            rnw_q     <= rnw_d;
            wdata_q   <= wdata_d;
            data_in_q <= data_in_d;
        end
    end

    // RW config bank, written on its strobe.
    always_ff @(posedge clk) begin
        // NOTE: this bank is a handful of flops, not a RAM, and its contents
        // are visible to the subsystem, so it is cleared on reset.
        if (reset) begin
            for (int i = 0; i < NUM_RW_REGS; i++) begin
                rw_regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_RW_REGS; i++) begin
                if (wr_strobe[i]) begin
                    rw_regs_q[i] <= wdata_q;
                end
            end
        end
    end

    // Flatten the RW bank onto the output bus, register 0 in the low word.
    always_comb begin
        rw_regs = '0;
        for (int i = 0; i < NUM_RW_REGS; i++) begin
            rw_regs[i*REG_WIDTH +: REG_WIDTH] = rw_regs_q[i];
        end
    end

endmodule

// File: tb/tb_io_bus_reg_slave.sv
// Self-checking bench for io_bus_reg_slave: transaction-level model compared
// every cycle, plus directed transfers with hand-computed expectations.
// The timeout scenario runs when IO_BUS_SLAVE_TIMEOUT_EN is defined.
module tb_io_bus_reg_slave;

    localparam logic [7:0] BASE = 8'h10;
    localparam int         NRW  = 4;
    localparam int         NRO  = 2;
    localparam int         TMO  = 10;

    logic              clk;
    logic              reset;
    logic [7:0]        reg_address;
    logic              RW;
    logic              handshake_1;
    logic [31:0]       data_out;
    logic [31:0]       data_in;
    logic              handshake_2;
    logic              selected;
    logic [NRW*32-1:0] rw_regs;
    logic [NRW-1:0]    wr_strobe;
    logic [NRO*32-1:0] ro_regs;
    logic              timeout_err;

    io_bus_reg_slave #(
        .BASE_ADDR      (BASE),
        .NUM_RW_REGS    (NRW),
        .NUM_RO_REGS    (NRO),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .reg_address (reg_address),
        .RW          (RW),
        .handshake_1 (handshake_1),
        .data_out    (data_out),
        .data_in     (data_in),
        .handshake_2 (handshake_2),
        .selected    (selected),
        .rw_regs     (rw_regs),
        .wr_strobe   (wr_strobe),
        .ro_regs     (ro_regs),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A transfer is tracked by its age in clock edges since acceptance:
    // age 1 = access cycle, age >= 2 = acknowledged.
    bit          m_busy, m_wait_low, m_err, m_h1_prev;
    int          m_age;
    bit          t_read;
    int          t_off;
    logic [31:0] t_data;
    logic [31:0] m_rdata;
    logic [31:0] m_rw [NRW];

    function automatic bit in_win(input logic [7:0] a);
        return (int'(a) >= int'(BASE)) && (int'(a) < int'(BASE) + NRW + NRO);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 0; m_wait_low = 0; m_err = 0; m_age = 0;
            m_h1_prev = 1; m_rdata = '0;
            for (int i = 0; i < NRW; i++) m_rw[i] = '0;
        end else begin
            if (m_wait_low) begin
                if (!handshake_1) m_wait_low = 0;
            end else if (m_busy) begin
                if (m_age == 1) begin
                    if (t_read) m_rdata = (t_off < NRW) ? m_rw[t_off] : ro_regs[(t_off-NRW)*32 +: 32];
                    else if (t_off < NRW) m_rw[t_off] = t_data;
                    m_age = 2;
                end else if (!handshake_1) begin
                    m_busy = 0; m_age = 0; m_rdata = '0;
                end
`ifdef IO_BUS_SLAVE_TIMEOUT_EN
                else if (m_age == 1 + TMO) begin
                    m_busy = 0; m_age = 0; m_rdata = '0; m_wait_low = 1; m_err = 1;
                end
`endif
                else begin
                    m_age++;
                end
            end else if (handshake_1 && !m_h1_prev && in_win(reg_address)) begin
                m_busy  = 1;
                m_age   = 1;
                t_read  = RW;
                t_off   = int'(reg_address) - int'(BASE);
                t_data  = data_out;
                m_rdata = '0;
            end
            m_h1_prev = handshake_1;
        end
    end

    logic              exp_sel, exp_hs2;
    logic [NRW-1:0]    exp_strobe;
    logic [NRW*32-1:0] exp_rw;
    always_comb begin
        exp_sel    = m_busy;
        exp_hs2    = m_busy && (m_age >= 2);
        exp_strobe = '0;
        if (m_busy && m_age == 1 && !t_read && t_off < NRW) exp_strobe = NRW'(1 << t_off);
        exp_rw = '0;
        for (int i = 0; i < NRW; i++) exp_rw[i*32 +: 32] = m_rw[i];
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_selected",    128'(selected),    128'(exp_sel));
            check("m_handshake_2", 128'(handshake_2), 128'(exp_hs2));
            check("m_data_in",     128'(data_in),     128'(m_rdata));
            check("m_wr_strobe",   128'(wr_strobe),   128'(exp_strobe));
            check("m_rw_regs",     128'(rw_regs),     128'(exp_rw));
            check("m_timeout_err", 128'(timeout_err), 128'(m_err));
        end
    end

    // ---------------- stimulus ----------------
    task automatic req(input logic [7:0] a, input logic r, input logic [31:0] d);
        @(negedge clk);
        reg_address = a; RW = r; data_out = d; handshake_1 = 1'b1;
    endtask

    task automatic wait_ack(output int edges, output int sc, output logic [NRW-1:0] sv);
        edges = 0; sc = 0; sv = '0;
        while (edges < 20) begin
            @(negedge clk);
            edges++;
            if (wr_strobe != '0) begin sc++; sv = wr_strobe; end
            if (handshake_2) break;
        end
    endtask

    task automatic release_bus(output int edges);
        @(negedge clk);
        handshake_1 = 1'b0;
        edges = 0;
        while (edges < 20) begin
            @(negedge clk);
            edges++;
            if (!handshake_2) break;
        end
    endtask

    task automatic do_txn(input logic [7:0] a, input logic r, input logic [31:0] d,
                          output int lat, output int sc, output logic [NRW-1:0] sv,
                          output logic [31:0] rd, output int rel);
        req(a, r, d);
        wait_ack(lat, sc, sv);
        rd = data_in;
        release_bus(rel);
    endtask

    int             lat, rel, sc, busy_seen, hi;
    logic [NRW-1:0] sv;
    logic [31:0]    rd;
    logic [7:0]     oow [2];

    initial begin
        reset = 1'b1; handshake_1 = 1'b0; RW = 1'b0; reg_address = '0; data_out = '0;
        ro_regs = {32'hCAFE_0001, 32'h0000_00A5};
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_handshake_2", 128'(handshake_2), 128'(0));
        check("rst_selected",    128'(selected),    128'(0));
        check("rst_data_in",     128'(data_in),     128'(0));
        check("rst_rw_regs",     128'(rw_regs),     128'(0));
        check("rst_timeout_err", 128'(timeout_err), 128'(0));
        reset = 1'b0;
        @(negedge clk);

        // Write DEADBEEF to RW register 2.
        do_txn(8'h12, 1'b0, 32'hDEAD_BEEF, lat, sc, sv, rd, rel);
        check("wr_ack_latency",   128'(lat), 128'(2));
        check("wr_strobe_cycles", 128'(sc),  128'(1));
        check("wr_strobe_value",  128'(sv),  128'(4'b0100));
        check("wr_release",       128'(rel), 128'(1));
        check("wr_rw_reg2",       128'(rw_regs[95:64]), 128'(32'hDEAD_BEEF));

        // Read RO status word 0.
        do_txn(8'h14, 1'b1, 32'h0, lat, sc, sv, rd, rel);
        check("ro0_ack_latency", 128'(lat), 128'(2));
        check("ro0_read_data",   128'(rd),  128'(32'h0000_00A5));
        check("ro0_release",     128'(rel), 128'(1));
        check("ro0_data_cleared", 128'(data_in), 128'(0));

        // Read back RW register 2.
        do_txn(8'h12, 1'b1, 32'h0, lat, sc, sv, rd, rel);
        check("rw2_read_data", 128'(rd), 128'(32'hDEAD_BEEF));
        check("rw2_no_strobe", 128'(sc), 128'(0));

        // Out-of-window accesses are never acknowledged.
        oow[0] = 8'h16; oow[1] = 8'h0F;
        for (int k = 0; k < 2; k++) begin
            req(oow[k], 1'b0, 32'hFFFF_FFFF);
            busy_seen = 0;
            repeat (50) begin
                @(negedge clk);
                if (handshake_2 || selected) busy_seen++;
            end
            check("oow_never_selected", 128'(busy_seen), 128'(0));
            handshake_1 = 1'b0;
            @(negedge clk);
        end
        check("oow_rw_unchanged", 128'(rw_regs), {32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0});

        // Write to an RO address: acknowledged but no effect.
        do_txn(8'h15, 1'b0, 32'h0000_1234, lat, sc, sv, rd, rel);
        check("rowr_ack_latency", 128'(lat), 128'(2));
        check("rowr_no_strobe",   128'(sc),  128'(0));
        do_txn(8'h15, 1'b1, 32'h0, lat, sc, sv, rd, rel);
        check("ro1_read_data",    128'(rd),  128'(32'hCAFE_0001));
        check("rowr_rw_unchanged", 128'(rw_regs), {32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0});

        // Reset while acknowledging with the request held high.
        req(8'h11, 1'b0, 32'h5555_5555);
        wait_ack(lat, sc, sv);
        check("rst_mid_ack_seen", 128'(handshake_2), 128'(1));
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_handshake_2", 128'(handshake_2), 128'(0));
        check("rst_mid_selected",    128'(selected),    128'(0));
        check("rst_mid_data_in",     128'(data_in),     128'(0));
        check("rst_mid_rw_regs",     128'(rw_regs),     128'(0));
        reset = 1'b0;
        busy_seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (handshake_2 || selected) busy_seen++;
        end
        check("held_req_ignored", 128'(busy_seen), 128'(0));
        handshake_1 = 1'b0;
        @(negedge clk);
        do_txn(8'h10, 1'b1, 32'h0, lat, sc, sv, rd, rel);
        check("post_rst_ack_latency", 128'(lat), 128'(2));
        check("post_rst_read_data",   128'(rd),  128'(0));

`ifdef IO_BUS_SLAVE_TIMEOUT_EN
        // Request held high past the timeout limit.
        req(8'h13, 1'b0, 32'h0000_0077);
        wait_ack(lat, sc, sv);
        check("tmo_ack_latency", 128'(lat), 128'(2));
        hi = 1;
        while (hi < 40) begin
            @(negedge clk);
            if (handshake_2) hi++;
            else break;
        end
        check("tmo_ack_cycles",  128'(hi),          128'(TMO));
        check("tmo_err_set",     128'(timeout_err), 128'(1));
        check("tmo_selected",    128'(selected),    128'(0));
        check("tmo_data_in",     128'(data_in),     128'(0));
        handshake_1 = 1'b0;
        @(negedge clk);
        do_txn(8'h14, 1'b1, 32'h0, lat, sc, sv, rd, rel);
        check("tmo_next_read",   128'(rd),          128'(32'h0000_00A5));
        check("tmo_err_sticky",  128'(timeout_err), 128'(1));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("tmo_err_cleared", 128'(timeout_err), 128'(0));
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
